// File: rtl/mem_bist_pkg.sv
// mem_bist_pkg: shared state encoding, default widths and the test pattern for mem_bist.
package mem_bist_pkg;
   localparam int DATA_WIDTH_DEF = 6;
   localparam int ADDR_WIDTH_DEF = 3;
   typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_WAIT, S_DONE} state_t;
   // {a, ~a} over aw bits each, then truncated or zero-extended to dw bits
   function automatic logic [31:0] pattern(input logic [31:0] a, input int unsigned aw, input int unsigned dw);
      logic [31:0] m;
      m = (32'd1 << aw) - 32'd1;
      return ((((a & m) << aw) | (~a & m)) & ((32'd1 << dw) - 32'd1));
   endfunction
endpackage

// File: rtl/mem_bist_cmp.sv
// mem_bist_cmp: registered read-data compare; vld marks the cycle mismatch is meaningful.
module mem_bist_cmp
   import mem_bist_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  RESET_L,
   input  logic                  en,
   input  logic [DATA_WIDTH-1:0] data_out,
   input  logic [DATA_WIDTH-1:0] expected,
   output logic                  mismatch,
   output logic                  vld
);
   logic mismatch_q, mismatch_d, vld_q, vld_d;
   always_comb begin
      mismatch_d = en && (data_out != expected);
      vld_d      = en;
   end
   always_ff @(posedge clk or negedge RESET_L) begin
      if (!RESET_L) begin
         mismatch_q <= 1'b0;
         vld_q      <= 1'b0;
      end else begin
         mismatch_q <= mismatch_d;
         vld_q      <= vld_d;
      end
   end
   assign mismatch = mismatch_q;
   assign vld      = vld_q;
endmodule

// File: rtl/mem_bist.sv
// mem_bist: two-phase pattern / inverted-pattern memory self test with
// read timeout, error-flag capture, first-fail address and saturating count.
module mem_bist
   import mem_bist_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int TIMEOUT    = 4
) (
   input  logic                  clk,
   input  logic                  RESET_L,
   input  logic                  start,
   output logic [ADDR_WIDTH-1:0] address,
   output logic [DATA_WIDTH-1:0] data,
   output logic                  write,
   output logic                  read,
   input  logic [DATA_WIDTH-1:0] data_out,
   input  logic                  valid_out,
   input  logic                  err,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [ADDR_WIDTH-1:0] fail_addr,
   output logic [3:0]            err_cnt
);
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam int NW = 1 << ADDR_WIDTH;
   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d, fail_addr_q, fail_addr_d;
   logic                  phase_q, phase_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [3:0]            err_cnt_q, err_cnt_d;
   logic [NW-1:0]         map_q, map_d;
   logic [DATA_WIDTH-1:0] pat, expd;
   logic                  last, cmp_en, mism, cmp_vld, tmo, resolve, rec;
   assign pat  = DATA_WIDTH'(pattern(32'(addr_q), ADDR_WIDTH, DATA_WIDTH));
   assign expd = phase_q ? ~pat : pat;
   assign last = &addr_q;
   // a response already captured blocks a second capture for the same read
   assign cmp_en  = (state_q == S_RD || state_q == S_WAIT) && valid_out && !cmp_vld;
   assign tmo     = state_q == S_WAIT && !cmp_vld && !valid_out && cnt_q == CW'(TIMEOUT - 1);
   assign resolve = state_q == S_WAIT && (cmp_vld || tmo);
   // map holds addresses already charged this phase, so each costs at most one failure
   assign rec = ((busy && err) || (cmp_vld && mism) || tmo) && !map_q[addr_q];
   mem_bist_cmp #(.DATA_WIDTH(DATA_WIDTH)) u_cmp (
      .clk      (clk),
      .RESET_L  (RESET_L),
      .en       (cmp_en),
      .data_out (data_out),
      .expected (expd),
      .mismatch (mism),
      .vld      (cmp_vld)
   );
   always_ff @(posedge clk or negedge RESET_L) begin
      if (!RESET_L) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         phase_q     <= 1'b0;
         cnt_q       <= '0;
         map_q       <= '0;
         err_cnt_q   <= '0;
         fail_addr_q <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         phase_q     <= phase_d;
         cnt_q       <= cnt_d;
         map_q       <= map_d;
         err_cnt_q   <= err_cnt_d;
         fail_addr_q <= fail_addr_d;
      end
   end
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      phase_d     = phase_q;
      cnt_d       = cnt_q;
      map_d       = map_q;
      err_cnt_d   = err_cnt_q;
      fail_addr_d = fail_addr_q;
      if (rec) begin
         map_d[addr_q] = 1'b1;
         err_cnt_d     = err_cnt_q + 4'(err_cnt_q != 4'hf);
         fail_addr_d   = (err_cnt_q == 4'd0) ? addr_q : fail_addr_q;
      end
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d     = S_WR;
               addr_d      = '0;
               phase_d     = 1'b0;
               map_d       = '0;
               err_cnt_d   = '0;
               fail_addr_d = '0;
            end
         end
         S_WR: begin
            addr_d = addr_q + 1'b1;
            if (last) state_d = S_RD;
         end
         S_RD: begin
            state_d = S_WAIT;
            cnt_d   = '0;
         end
         S_WAIT: begin
            cnt_d = cnt_q + 1'b1;
            if (resolve) begin
               addr_d  = addr_q + 1'b1;
               state_d = !last ? S_RD : (phase_q ? S_DONE : S_WR);
               if (last && !phase_q) begin
                  phase_d = 1'b1;
                  map_d   = '0;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end
   always_comb begin
      write     = state_q == S_WR;
      read      = state_q == S_RD;
      busy      = write || read || state_q == S_WAIT;
      done      = state_q == S_DONE;
      address   = addr_q;
      data      = write ? expd : '0;
      pass      = done && err_cnt_q == 4'd0;
      fail_addr = fail_addr_q;
      err_cnt   = err_cnt_q;
   end
endmodule
